// File: rtl/ex_muldiv_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_if
// Brief    : EX-stage M-extension request/response bundle for ex_muldiv.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, flush, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b,
    output busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Brief    : Iterative RV32M multiply/divide unit (radix-2, 32 steps).
//            Optional MULDIV_FAST_MUL_EN: single-cycle multiplies.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);

  localparam int               c_CW   = $clog2(WIDTH);
  localparam logic [1:0]       c_IDLE = 2'd0;
  localparam logic [1:0]       c_CALC = 2'd1;
  localparam logic [1:0]       c_DONE = 2'd2;
  localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_ONES = '1;

  logic [1:0]         r_state, w_next;
  logic [c_CW-1:0]    r_cnt;
  logic [2:0]         r_f3;
  logic               r_nq, r_nr;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b, r_res;

  logic               w_accept, w_is_div, w_dz, w_ovf, w_fast, w_to_done;
  logic               w_a_sgn_t, w_b_sgn_t, w_sa, w_sb, w_ge;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_sub;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_fast_acc, w_step, w_fin_acc;
  logic [2:0]         w_fin_f3;
  logic               w_fin_nq, w_fin_nr;

  // Final sign fix and result selection; acc holds {hi,lo} product or {rem,quot}.
  function automatic logic [WIDTH-1:0] f_fix(input logic [2*WIDTH-1:0] acc,
                                             input logic [2:0] f3,
                                             input logic nq, input logic nr);
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   q, r, v;
    p = nq ? -acc : acc;
    q = nq ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r = nr ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    case (f3)
      3'b000:                v = p[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: v = p[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:        v = q;
      default:               v = r;
    endcase
    return v;
  endfunction

  always_comb begin
    w_a_sgn_t = 1'b0;
    w_b_sgn_t = 1'b0;
    case (bus.funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        w_a_sgn_t = 1'b1;
        w_b_sgn_t = 1'b1;
      end
      3'b010:  w_a_sgn_t = 1'b1;
      default: ;
    endcase
  end

  assign w_sa     = w_a_sgn_t & bus.op_a[WIDTH-1];
  assign w_sb     = w_b_sgn_t & bus.op_b[WIDTH-1];
  assign w_mag_a  = w_sa ? -bus.op_a : bus.op_a;
  assign w_mag_b  = w_sb ? -bus.op_b : bus.op_b;
  assign w_accept = bus.start & ~bus.flush;
  assign w_is_div = bus.funct3[2];
  assign w_dz     = w_is_div & (bus.op_b == '0);
  assign w_ovf    = w_is_div & ~bus.funct3[0] & (bus.op_a == c_MIN) & (bus.op_b == c_ONES);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod;
  // Value-extended operands make a truncated 2W-bit multiply equal the 33x33 signed product.
  assign w_ext_a = {{WIDTH{w_sa}}, bus.op_a};
  assign w_ext_b = {{WIDTH{w_sb}}, bus.op_b};
  assign w_prod  = w_ext_a * w_ext_b;
  assign w_fast  = w_dz | w_ovf | ~w_is_div;

  always_comb begin
    w_fast_acc = w_prod;
    if (w_dz)       w_fast_acc = {bus.op_a, c_ONES};
    else if (w_ovf) w_fast_acc = {{WIDTH{1'b0}}, c_MIN};
  end
`else
  assign w_fast = w_dz | w_ovf;

  always_comb begin
    w_fast_acc = {{WIDTH{1'b0}}, c_MIN};
    if (w_dz) w_fast_acc = {bus.op_a, c_ONES};
  end
`endif

  // One iteration: restoring divide on {rem,quot} or shift-add multiply on {hi,multiplier}.
  always_comb begin
    w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
    w_ge  = r_acc[2*WIDTH-1:WIDTH-1] >= {1'b0, r_b};
    w_sub = r_acc[2*WIDTH-2:WIDTH-1] - r_b;
    if (r_f3[2])
      w_step = w_ge ? {w_sub, r_acc[WIDTH-2:0], 1'b1} : {r_acc[2*WIDTH-2:0], 1'b0};
    else
      w_step = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_next = w_fast ? c_DONE : c_CALC;
      c_CALC: begin
        if (bus.flush)            w_next = c_IDLE;
        else if (r_cnt == c_LAST) w_next = c_DONE;
      end
      c_DONE:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    if (!rst) begin
      case (r_state)
        c_IDLE:  bus.busy = w_accept;
        c_CALC:  bus.busy = 1'b1;
        c_DONE:  bus.done = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_to_done = (w_next == c_DONE) & (r_state != c_DONE);
  assign w_fin_acc = (r_state == c_IDLE) ? w_fast_acc : w_step;
  assign w_fin_f3  = (r_state == c_IDLE) ? bus.funct3 : r_f3;
  assign w_fin_nq  = (r_state == c_IDLE) ? 1'b0 : r_nq;
  assign w_fin_nr  = (r_state == c_IDLE) ? 1'b0 : r_nr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_f3  <= '0;
      r_nq  <= 1'b0;
      r_nr  <= 1'b0;
      r_acc <= '0;
      r_b   <= '0;
      r_res <= '0;
    end else begin
      if (r_state == c_IDLE && w_accept) begin
        r_f3  <= bus.funct3;
        r_cnt <= '0;
        r_nq  <= w_sa ^ w_sb;
        r_nr  <= w_sa;
        r_acc <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
        r_b   <= w_is_div ? w_mag_b : w_mag_a;
      end else if (r_state == c_CALC) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_to_done)
        r_res <= f_fix(w_fin_acc, w_fin_f3, w_fin_nq, w_fin_nr);
    end
  end

  assign bus.result = r_res;

endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the registered operands and funct3 of an M-extension instruction and produces a 32-bit result. While it works, it raises `busy`, which holds the ID/EX and IF/ID registers and the PC. The result is presented to the EX/MEM register through the normal EX result mux in the cycle `done` pulses.

## Interface
- `WIDTH`, default 32: operand/result width; only 32 is supported.
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  valid M-extension op in EX: opcode OP and funct7 = 0000001, from the ID/EX outputs
- `flush`  in  1  kill the current op; takes priority over `start`
- `funct3`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `op_a`  in  WIDTH  rs1 value (dividend / multiplicand)
- `op_b`  in  WIDTH  rs2 value (divisor / multiplier)
- `busy`  out  1  stall request to the front-end and the ID/EX enable
- `done`  out  1  one-cycle pulse; `result` is valid this cycle
- `result`  out  WIDTH  registered result, held until the next `done`

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**
  - `start`=1 and `flush`=0: latch `funct3` and operands, convert signed operands to magnitudes, record result sign, count=0, go to CALC.
  - Fast path: div-by-zero and signed overflow go straight to DONE.
- **CALC**
  - One radix-2 step per cycle: restoring division or shift-add multiply on a 64-bit accumulator.
  - Counter 0..31; at count==31, go to DONE.
- **DONE**
  - Apply sign fix (two's-complement negate if the sign flag is set), register `result`, assert `done`.
  - `start` is ignored, because the same instruction is still in ID/EX. Go to IDLE.
- **Signedness**
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: `op_a` signed, `op_b` unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- **Result selection**
  - MUL: product[31:0].
  - MULH*: product[63:32].
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- **Divide by zero**: quotient = 0xFFFFFFFF; remainder = `op_a`.
- **Overflow** (DIV/REM, 0x80000000 / 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- **`busy`**
  - Combinational: (IDLE & `start` & !`flush`) | CALC.
  - Low in DONE, so the pipeline advances at the end of the DONE cycle.
- **`flush`**: in any state, go to IDLE at the next edge. `done` is not asserted and `result` is unchanged.
- **Reset** (asynchronous, any time, including mid-CALC)
  - state = IDLE, `result` = 0, `done` = 0, counter = 0.
  - `busy` is forced to 0 while `rst` is high.

## Timing
- Cycle 0 = first cycle `start` is high in IDLE. `busy`=1 from cycle 0.
- Iterative ops: CALC occupies cycles 1..32. DONE is cycle 33: `done`=1, `busy`=0. EX/MEM captures the result at the end of cycle 33.
- Fast-path ops (div-by-zero, overflow): DONE at cycle 1; `busy` high only in cycle 0.
- Back-to-back M ops: the next `start` is accepted in the first IDLE cycle after DONE, i.e. cycle 34.
- `result` changes only in the DONE cycle.
- Outputs after reset: `busy`=0, `done`=0, `result`=0.

## Configuration
- **`MULDIV_FAST_MUL_EN` defined**
  - MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed multiply.
  - IDLE goes directly to DONE, so `done` is at cycle 1 and `busy` is high only in cycle 0.
- **Not defined**: multiplies use the 32-step iterative path (DONE at cycle 33).
- Division is always iterative.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3) -> `result`=0xFFFFFFEB; `done` at cycle 33 (cycle 1 with `MULDIV_FAST_MUL_EN`); `busy` high for exactly 33 cycles (1 cycle with the macro).
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFEC (-20) / 3 -> 0xFFFFFFFA.
- REM with the same operands -> 0xFFFFFFFE.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0; both with `done` at cycle 1.
- Flush and reset abort:
  - `flush` at cycle 10 of a DIVU -> `busy`=0 at cycle 11, no `done`, `result` keeps its previous value.
  - `rst` pulse at cycle 20 -> `result`=0, IDLE, `busy`=0 immediately.
- Back-to-back DIVU 100/7 then REMU 100/7, with `start` held -> results 14 then 2; exactly one `done` per op; second `done` at cycle 67.
